// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared constants, config enum and status type for the CCE memory credit tracker.
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_inv_cfg
    } bp_params_e;

    localparam int mem_credits_default_lp = 8;
    localparam int timeout_default_lp     = 4096;
    localparam int stamp_width_default_lp = 32;
    localparam int outstanding_width_lp   = 16;

    typedef struct packed {
        logic                            timeout;
        logic                            underflow;
        logic [outstanding_width_lp-1:0] outstanding;
    } bp_me_cce_mem_credit_status_s;

    function automatic int cce_mem_msg_width(bp_params_e cfg);
        return (cfg == e_bp_inv_cfg) ? 96 : 128;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: circular timestamp FIFO; the caller guarantees no push when full and no pop when empty.
module bsg_fifo_1r1w_small #(
    parameter int  width_p      = 32,
    parameter int  els_p        = 8,
    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               yumi_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0]      mem_q [els_p];
    logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;

    assign data_o = mem_q[rptr_q];

    // Advance each pointer on its own strobe, wrapping at the last slot.
    always_comb begin
        wptr_d = v_i ? ((wptr_q == ptr_width_lp'(els_p - 1)) ? '0 : wptr_q + ptr_width_lp'(1)) : wptr_q;
        rptr_d = yumi_i ? ((rptr_q == ptr_width_lp'(els_p - 1)) ? '0 : rptr_q + ptr_width_lp'(1)) : rptr_q;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset; only slots behind the write pointer are ever read.
    always_ff @(posedge clk_i) begin
        if (v_i) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/bp_me_cce_mem_credit_tracker.sv
// bp_me_cce_mem_credit_tracker: credit gate on CCE mem_cmd with response timeout/underflow flags.
// Optional latency/response statistics with BP_ME_CCE_MEM_CREDIT_TRACKER_STATS_EN.
module bp_me_cce_mem_credit_tracker
    import bp_me_pkg::*;
#(
    parameter bp_params_e bp_params_p      = e_bp_inv_cfg,
    parameter int         mem_credits_p    = mem_credits_default_lp,
    parameter int         timeout_p        = timeout_default_lp,
    parameter int         stamp_width_p    = stamp_width_default_lp,
    localparam int        cce_mem_msg_width_lp = cce_mem_msg_width(bp_params_p),
    localparam int        out_width_lp     = $clog2(mem_credits_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
    output logic                            mem_cmd_v_o,
    input  logic                            mem_cmd_ready_i,
    input  logic                            mem_resp_v_i,
    input  logic                            mem_resp_yumi_i,
    output logic                            credits_empty_o,
    output logic                            credits_full_o,
    output logic [out_width_lp-1:0]         outstanding_o,
    output logic                            timeout_o,
`ifdef BP_ME_CCE_MEM_CREDIT_TRACKER_STATS_EN
    output logic [stamp_width_p-1:0]        max_latency_o,
    output logic [31:0]                     total_resp_o,
`endif
    output logic                            underflow_o
);

    bp_me_cce_mem_credit_status_s status_q, status_d;
    logic [stamp_width_p-1:0]     counter_q, counter_d, head_stamp, elapsed;
    logic                         has_credit, send, ret, pop;

    // Credit check uses registered state only, so a same-cycle return never frees a send.
    assign has_credit      = status_q.outstanding < outstanding_width_lp'(mem_credits_p);
    assign mem_cmd_o       = mem_cmd_i;
    assign mem_cmd_v_o     = mem_cmd_v_i & has_credit;
    assign mem_cmd_ready_o = mem_cmd_ready_i & has_credit;
    assign send            = mem_cmd_v_i & mem_cmd_ready_o;
    assign ret             = mem_resp_v_i & mem_resp_yumi_i;
    assign pop             = ret & (status_q.outstanding != '0);
    assign elapsed         = counter_q - head_stamp;
    assign credits_empty_o = ~has_credit;
    assign credits_full_o  = (status_q.outstanding == '0);
    assign outstanding_o   = status_q.outstanding[out_width_lp-1:0];
    assign timeout_o       = status_q.timeout;
    assign underflow_o     = status_q.underflow;

    bsg_fifo_1r1w_small #(
        .width_p(stamp_width_p),
        .els_p  (mem_credits_p)
    ) stamp_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (send),
        .data_i   (counter_q),
        .yumi_i   (pop),
        .data_o   (head_stamp)
    );

    // Next counter, outstanding count and sticky error flags.
    always_comb begin
        counter_d = counter_q + stamp_width_p'(1);
        status_d = status_q;
        status_d.outstanding = status_q.outstanding + outstanding_width_lp'(send) - outstanding_width_lp'(pop);
        status_d.underflow = status_q.underflow | (ret & ~pop);
        status_d.timeout = status_q.timeout | ((status_q.outstanding != '0) & (elapsed >= stamp_width_p'(timeout_p)));
    end

    // Core state registers; reset drops all in-flight credits.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            status_q  <= '0;
            counter_q <= '0;
        end else begin
            status_q  <= status_d;
            counter_q <= counter_d;
        end
    end

`ifdef BP_ME_CCE_MEM_CREDIT_TRACKER_STATS_EN
    logic [stamp_width_p-1:0] max_latency_q, max_latency_d;
    logic [31:0]              total_resp_q, total_resp_d;

    assign max_latency_o = max_latency_q;
    assign total_resp_o  = total_resp_q;

    // Track worst popped latency and a saturating pop count.
    always_comb begin
        max_latency_d = (pop && (elapsed > max_latency_q)) ? elapsed : max_latency_q;
        total_resp_d  = (pop && (total_resp_q != '1)) ? total_resp_q + 32'd1 : total_resp_q;
    end

    // Statistics registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            max_latency_q <= '0;
            total_resp_q  <= '0;
        end else begin
            max_latency_q <= max_latency_d;
            total_resp_q  <= total_resp_d;
        end
    end
`endif

endmodule

// File: doc/bp_me_cce_mem_credit_tracker.md
Name: bp_me_cce_mem_credit_tracker

Overview:
- Sits directly downstream of the CCE memory-command port and upstream of the memory network.
- Gates CCE mem_cmd handshakes against a fixed pool of outstanding-transaction credits. Credits return on mem_resp consumption by the CCE.
- Timestamps each command in order and flags memory-response timeout and credit underflow.
- Its handshake outputs are the mem_cmd/mem_resp valid/ready/yumi signals the CCE tracer observes.

Parameters:
- bp_params_p, e_bp_inv_cfg: processor configuration; supplies cce_mem_msg_width_lp.
- mem_credits_p, 8: maximum outstanding memory commands (≥1).
- timeout_p, 4096: cycles from command handshake to response before timeout is flagged.
- stamp_width_p, 32: cycle counter/timestamp width; requires timeout_p < 2^stamp_width_p.

Ports:
- clk_i, input, 1: clock.
- reset_n_i, input, 1: reset, synchronous, active-low.
- mem_cmd_i, input, cce_mem_msg_width_lp: command from CCE.
- mem_cmd_v_i, input, 1: command valid from CCE.
- mem_cmd_ready_o, output, 1: ready to CCE.
- mem_cmd_o, output, cce_mem_msg_width_lp: command to memory; combinational copy of mem_cmd_i.
- mem_cmd_v_o, output, 1: valid to memory.
- mem_cmd_ready_i, input, 1: ready from memory.
- mem_resp_v_i, input, 1: response valid into CCE (observed only).
- mem_resp_yumi_i, input, 1: CCE consumes response (observed only).
- credits_empty_o, output, 1: no credits available.
- credits_full_o, output, 1: all credits home; nothing outstanding.
- outstanding_o, output, clog2(mem_credits_p+1): current outstanding count.
- timeout_o, output, 1: sticky timeout error.
- underflow_o, output, 1: sticky error, response with nothing outstanding.

Behaviour:
- Reset values (reset_n_i low at clock edge): outstanding=0, cycle counter=0, timeout_o=0, underflow_o=0, timestamp FIFO empty, credits_full_o=1, credits_empty_o=0.
- Reset mid-operation discards all in-flight state; no credit is recovered later.
- Cycle counter increments every non-reset cycle and wraps modulo 2^stamp_width_p.
- Handshake rules:
  - has_credit = (outstanding < mem_credits_p).
  - mem_cmd_v_o = mem_cmd_v_i & has_credit.
  - mem_cmd_ready_o = mem_cmd_ready_i & has_credit.
  - Send = mem_cmd_v_i & mem_cmd_ready_o.
  - No same-cycle credit bypass: a response returning when outstanding==mem_credits_p does not enable a send that cycle.
  - Zero latency: no register on the command path.
- Send: push the current counter value into the timestamp FIFO; outstanding += 1.
- Return (mem_resp_v_i & mem_resp_yumi_i):
  - If outstanding>0: pop FIFO; outstanding -= 1.
  - If outstanding==0: set underflow_o; count stays 0; FIFO untouched.
- Send and return in the same cycle: outstanding unchanged; FIFO pushes and pops simultaneously, which is legal when full or empty within the credit rules.
- Timeout:
  - Condition: outstanding>0 and (counter − head_stamp) mod 2^stamp_width_p ≥ timeout_p.
  - timeout_o sets the next cycle and stays set until reset.
  - Commands are not blocked after an error; errors are observation only.
- credits_empty_o = ~has_credit; credits_full_o = (outstanding==0).
- Responses are in order (single memory channel), so the FIFO head always matches the oldest command.

Optional Feature:
- Macro: BP_ME_CCE_MEM_CREDIT_TRACKER_STATS_EN.
- When defined, adds outputs:
  - max_latency_o, stamp_width_p: largest latency popped since reset.
  - total_resp_o, 32: count of returns, saturating.
- Both are updated on the cycle after a pop.
- When undefined, these ports and registers are absent and the core behaviour is identical.

Decomposition:
- Shared package bp_me_pkg gets:
  - Default constants for credit count and timeout.
  - A typedef for the tracker status struct {timeout, underflow, outstanding}.
- One sub-module, bsg_fifo_1r1w_small: the timestamp FIFO, depth mem_credits_p, width stamp_width_p.

Test Plan:
- Credit limit: hold mem_cmd_v_i=1, mem_cmd_ready_i=1, no responses, mem_credits_p=8. Required: exactly 8 sends; then ready_o=0, credits_empty_o=1, outstanding_o=8.
- Simultaneous send and return: at outstanding=3, send and return in the same cycle. Required: outstanding stays 3. At outstanding=8, a return-only cycle gives 7, and a send is accepted only in the next cycle.
- Timeout: timeout_p=16, one send, no response. Required: timeout_o rises on the cycle after elapsed=16 and is still 1 after a late response.
- Underflow: a return with outstanding=0. Required: underflow_o=1, outstanding_o=0, and the next send still works.
- Reset mid-flight: 5 outstanding, then reset_n_i=0 for one cycle. Required: outstanding_o=0, credits_full_o=1, errors clear.
- Wrap: stamp_width_p=8, timeout_p=200, send at counter 250, response at counter 40. Required: no timeout; with STATS_EN, max_latency_o=46.
